fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 135 +++++++++++++
 tb/tb_fetch_stage.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: single-issue instruction fetch with an IF/ID pipeline register.
//
// Each cycle, exactly one of these applies, highest priority first:
//   halted > stall > branch_taken > halt-fetch > normal fetch.
// The halted flag is sticky and only rst clears it.
//
// Handshake: there is no valid/ready pair on the imem side. imem_data is a
// combinational read of imem_addr. Downstream back-pressure is the single
// 'stall' input: while it is high (and fetch is not halted), the PC and the
// whole IF/ID register hold. IFID_valid marks a real instruction (1) or a
// bubble (0).
//
// Optional feature: define FETCH_PERF_EN to build the saturating
// stall_count / flush_count performance counters. Without it, both outputs
// are tied to zero and no counter flops exist.
module fetch_stage #(
  parameter logic [15:0] BUBBLE_INSTR = 16'h0000,
  parameter logic [3:0]  HALT_OP      = 4'hF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [15:0] branch_target,
  input  logic [15:0] imem_data,
  output logic [15:0] imem_addr,
  output logic [15:0] IFID_instr,
  output logic [15:0] IFID_pc_plus2,
  output logic        IFID_valid,
  output logic        halted,
  output logic [15:0] stall_count,
  output logic [15:0] flush_count
);

  logic [15:0] pc_q, pc_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] pc_plus2_q, pc_plus2_d;
  logic        valid_q, valid_d;
  logic        halted_q, halted_d;
  logic [15:0] pc_inc;

  // Sequential PC + 2. Wraps modulo 2^16 and raises no flag.
  assign pc_inc = pc_q + 16'd2;

  // Next-state selection in priority order: halted, stall, branch, halt-fetch, normal.
  always_comb begin
    pc_d       = pc_q;
    instr_d    = instr_q;
    pc_plus2_d = pc_plus2_q;
    valid_d    = valid_q;
    halted_d   = halted_q;
    if (halted_q) begin
      instr_d    = BUBBLE_INSTR;
      pc_plus2_d = 16'h0000;
      valid_d    = 1'b0;
    end else if (stall) begin
      // Hold everything. A branch in the same cycle is ignored.
    end else if (branch_taken) begin
      // Redirect, and squash the wrong-path word fetched this cycle.
      // This also covers a halt opcode that arrives on the wrong path.
      pc_d       = {branch_target[15:1], 1'b0};
      instr_d    = BUBBLE_INSTR;
      pc_plus2_d = 16'h0000;
      valid_d    = 1'b0;
    end else if (imem_data[15:12] == HALT_OP) begin
      // Hand the halt to ID, freeze the PC and go sticky-halted.
      instr_d    = imem_data;
      pc_plus2_d = pc_inc;
      valid_d    = 1'b1;
      halted_d   = 1'b1;
    end else begin
      pc_d       = pc_inc;
      instr_d    = imem_data;
      pc_plus2_d = pc_inc;
      valid_d    = 1'b1;
    end
  end

  // PC and IF/ID registers. Async reset makes fetch restart at address 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= 16'h0000;
      instr_q    <= BUBBLE_INSTR;
      pc_plus2_q <= 16'h0000;
      valid_q    <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      pc_plus2_q <= pc_plus2_d;
      valid_q    <= valid_d;
      halted_q   <= halted_d;
    end
  end

  assign imem_addr     = pc_q;
  assign IFID_instr    = instr_q;
  assign IFID_pc_plus2 = pc_plus2_q;
  assign IFID_valid    = valid_q;
  assign halted        = halted_q;

`ifdef FETCH_PERF_EN
  logic        stall_evt, flush_evt;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  // Count stalled cycles and branch flushes. Both counters saturate at all-ones.
  always_comb begin
    stall_evt   = !halted_q && stall;
    flush_evt   = !halted_q && !stall && branch_taken;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_evt && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
    if (flush_evt && (flush_cnt_q != 16'hFFFF)) flush_cnt_d = flush_cnt_q + 16'd1;
  end

  // Performance counter registers. Reset clears them like all other state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= 16'h0000;
      flush_cnt_q <= 16'h0000;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_count = stall_cnt_q;
  assign flush_count = flush_cnt_q;
`else
  assign stall_count = 16'h0000;
  assign flush_count = 16'h0000;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed self-checking bench for fetch_stage.
// Each step pushes its expected outputs to exp_q before the clock edge.
// After the edge, the step pops that entry and compares it with the DUT.
module tb_fetch_stage;

  localparam logic [15:0] BUBBLE = 16'h0000;
  localparam int W = 50; // {pc, valid, instr, pc_plus2, halted}

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [15:0] branch_target = 16'h0000;
  logic [15:0] imem_data = 16'h0000;
  logic [15:0] imem_addr, IFID_instr, IFID_pc_plus2, stall_count, flush_count;
  logic        IFID_valid, halted;

  logic [W-1:0] exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] exp_stall_cnt = 16'h0000;
  logic [15:0] exp_flush_cnt = 16'h0000;
  logic [15:0] pc_m;
  logic [15:0] d;
  logic [15:0] held_i, held_p;

  fetch_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .imem_data(imem_data),
    .imem_addr(imem_addr), .IFID_instr(IFID_instr), .IFID_pc_plus2(IFID_pc_plus2),
    .IFID_valid(IFID_valid), .halted(halted),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  // ---- clock ----
  always #5 clk = ~clk;

  // ---- checking ----
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic note_stall();
`ifdef FETCH_PERF_EN
    exp_stall_cnt = exp_stall_cnt + 16'd1;
`endif
  endtask

  task automatic note_flush();
`ifdef FETCH_PERF_EN
    exp_flush_cnt = exp_flush_cnt + 16'd1;
`endif
  endtask

  // Pop one scoreboard entry and compare every output against it.
  task automatic check_out(input string tag);
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 16'd0, 16'd1);
      return;
    end
    e = exp_q.pop_front();
    chk({tag, "_pc"},     imem_addr,             e[49:34]);
    chk({tag, "_valid"},  {15'd0, IFID_valid},   {15'd0, e[33]});
    chk({tag, "_instr"},  IFID_instr,            e[32:17]);
    chk({tag, "_pp2"},    IFID_pc_plus2,         e[16:1]);
    chk({tag, "_halted"}, {15'd0, halted},       {15'd0, e[0]});
    chk({tag, "_scnt"},   stall_count,           exp_stall_cnt);
    chk({tag, "_fcnt"},   flush_count,           exp_flush_cnt);
  endtask

  // ---- driver: apply one cycle of inputs with its expected result ----
  task automatic step(input string tag, input logic s, input logic b,
                      input logic [15:0] t, input logic [15:0] dat,
                      input logic [15:0] e_pc, input logic e_v,
                      input logic [15:0] e_i, input logic [15:0] e_p,
                      input logic e_h);
    stall = s; branch_taken = b; branch_target = t; imem_data = dat;
    exp_q.push_back({e_pc, e_v, e_i, e_p, e_h});
    @(posedge clk); #1;
    check_out(tag);
  endtask

  // A normal non-halt fetch at the modelled PC.
  task automatic fetch(input string tag, input logic [15:0] dat);
    pc_m = pc_m + 16'd2;
    step(tag, 1'b0, 1'b0, 16'h0000, dat, pc_m, 1'b1, dat, pc_m, 1'b0);
  endtask

  function automatic logic [15:0] rnd_instr();
    return 16'($urandom_range(0, 16'hEFFF));
  endfunction

  // ---- reset helper: assert mid-cycle, check immediately, release after negedge ----
  task automatic apply_reset(input string tag);
    @(negedge clk); #2;
    rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; imem_data = 16'h0000;
    #1;
    exp_stall_cnt = 16'h0000; exp_flush_cnt = 16'h0000;
    exp_q.push_back({16'h0000, 1'b0, BUBBLE, 16'h0000, 1'b0});
    check_out(tag);
    @(negedge clk); rst = 1'b0;
    pc_m = 16'h0000;
    #1;
  endtask

  initial begin
    // Asynchronous reset before any clock edge.
    #1 rst = 1'b1;
    #1;
    exp_q.push_back({16'h0000, 1'b0, BUBBLE, 16'h0000, 1'b0});
    check_out("rst_async");
    @(negedge clk); rst = 1'b0;
    pc_m = 16'h0000;

    // Three fetches of 1123 at PCs 0, 2 and 4.
    for (int i = 0; i < 3; i++) fetch($sformatf("seq1123_%0d", i), 16'h1123);

    // Walk the PC to 0x0010, then stall for two cycles.
    for (int i = 0; i < 5; i++) fetch($sformatf("walk10_%0d", i), rnd_instr());
    held_i = IFID_instr; held_p = IFID_pc_plus2;
    chk("walk10_pc_reached", imem_addr, 16'h0010);
    for (int i = 0; i < 2; i++) begin
      note_stall();
      step($sformatf("stall_%0d", i), 1'b1, 1'b0, 16'h0000, rnd_instr(),
           16'h0010, 1'b1, held_i, held_p, 1'b0);
    end

    // Walk to 0x0020, then take a branch to the odd target 0x0101.
    for (int i = 0; i < 8; i++) fetch($sformatf("walk20_%0d", i), rnd_instr());
    note_flush();
    step("branch_0101", 1'b0, 1'b1, 16'h0101, rnd_instr(), 16'h0100, 1'b0, BUBBLE, 16'h0000, 1'b0);
    pc_m = 16'h0100;

    // Stall together with a branch: everything holds and no flush is counted.
    note_stall();
    step("stall_branch", 1'b1, 1'b1, 16'h4444, rnd_instr(), 16'h0100, 1'b0, BUBBLE, 16'h0000, 1'b0);

    // A fetch after the redirect comes from the branch target.
    fetch("post_branch", 16'h2345);

    // Halt at 0x0008: branch there first, then fetch F000.
    note_flush();
    step("branch_0008", 1'b0, 1'b1, 16'h0008, rnd_instr(), 16'h0008, 1'b0, BUBBLE, 16'h0000, 1'b0);
    step("halt_fetch", 1'b0, 1'b0, 16'h0000, 16'hF000, 16'h0008, 1'b1, 16'hF000, 16'h000A, 1'b1);
    step("halted_bubble", 1'b0, 1'b0, 16'h0000, 16'h1111, 16'h0008, 1'b0, BUBBLE, 16'h0000, 1'b1);
    // While halted, stall and branch are ignored and no counter moves.
    step("halted_ignore", 1'b1, 1'b1, 16'h0040, 16'h2222, 16'h0008, 1'b0, BUBBLE, 16'h0000, 1'b1);
    apply_reset("rst_clears_halt");

    // After reset, the first edge fetches from address 0.
    fetch("after_rst", 16'h3456);

    // A halt that arrives alongside a taken branch is flushed.
    note_flush();
    step("halt_vs_branch", 1'b0, 1'b1, 16'h0030, 16'hF123, 16'h0030, 1'b0, BUBBLE, 16'h0000, 1'b0);
    pc_m = 16'h0030;
    fetch("no_halt_after", 16'h0777);

    // PC wraps from FFFE to 0000.
    note_flush();
    step("branch_fffe", 1'b0, 1'b1, 16'hFFFE, rnd_instr(), 16'hFFFE, 1'b0, BUBBLE, 16'h0000, 1'b0);
    d = rnd_instr();
    step("wrap", 1'b0, 1'b0, 16'h0000, d, 16'h0000, 1'b1, d, 16'h0000, 1'b0);
    pc_m = 16'h0000;
    fetch("after_wrap", rnd_instr());

    chk("sb_drained", 16'(exp_q.size()), 16'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
